// File: rtl/i2c_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// i2c_arbiter: round-robin arbiter sharing one I2C engine, with NACK retry and timeout. Rev 1.0
//------------------------------------------------------------------------------
module i2c_arbiter #(
   parameter int NREQ      = 3,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 1_000_000
) (
   input  logic                 iCLK,
   input  logic                 iRST_N,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [24*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      nack,
   output logic                 m_start,
   output logic [23:0]          m_data,
   input  logic                 m_end,
   input  logic                 m_ack,
   output logic                 busy,
   output logic [1:0]           grant_id
);

   localparam int              C_RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int              C_TW        = $clog2(TIMEOUT + 1);
   localparam logic [C_RW-1:0] C_MAX_RETRY = C_RW'(MAX_RETRY);
   localparam logic [C_TW-1:0] C_TMO_MAX   = C_TW'(TIMEOUT);
   localparam logic [C_TW-1:0] C_TMO_LAST  = C_TW'(TIMEOUT - 1);
   localparam logic [1:0]      C_LAST_RST  = 2'(NREQ - 1);
   localparam logic [NREQ-1:0] C_ONE       = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GO    = 2'd1,
      S_RUN   = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [23:0]       r_m_data;
   logic [1:0]        r_grant;
   logic [1:0]        r_last_grant;
   logic [C_RW-1:0]   r_retry;
   logic [C_TW-1:0]   r_tmo;
   logic [NREQ-1:0]   r_req_ready;
   logic [NREQ-1:0]   r_done;
   logic [NREQ-1:0]   r_nack;

   logic [3:0]        w_valid4;
   logic [23:0]       w_word [4];
   logic              w_arb_hit;
   logic [1:0]        w_arb_idx;
   logic [2:0]        w_sum;
   logic [NREQ-1:0]   w_arb_oh;
   logic [NREQ-1:0]   w_grant_oh;
   logic              w_tmo_hit;
   logic              w_grant_now;
   logic              w_retry_inc;
   logic              w_tmo_clr;
   logic              w_fin;
   logic              w_fin_nack;

   // Pad requester vectors to four slots so the arbiter can index with a 2-bit id.
   for (genvar i = 0; i < 4; i++) begin : g_pad
      if (i < NREQ) begin : g_used
         assign w_valid4[i] = req_valid[i];
         assign w_word[i]   = req_data[24*i +: 24];
      end else begin : g_unused
         assign w_valid4[i] = 1'b0;
         assign w_word[i]   = 24'd0;
      end
   end

   // Search begins one past the previous owner and wraps at NREQ.
   always_comb begin
      w_arb_hit = 1'b0;
      w_arb_idx = 2'd0;
      w_sum     = 3'd0;
      for (int k = 1; k <= NREQ; k++) begin
         w_sum = {1'b0, r_last_grant} + 3'(k);
         if (w_sum >= 3'(NREQ)) begin
            w_sum = w_sum - 3'(NREQ);
         end
         if (!w_arb_hit && w_valid4[w_sum[1:0]]) begin
            w_arb_hit = 1'b1;
            w_arb_idx = w_sum[1:0];
         end
      end
   end

   assign w_arb_oh   = C_ONE << w_arb_idx;
   assign w_grant_oh = C_ONE << r_grant;
   assign w_tmo_hit  = (r_tmo >= C_TMO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_now = 1'b0;
      w_retry_inc = 1'b0;
      w_tmo_clr   = 1'b0;
      w_fin       = 1'b0;
      w_fin_nack  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (m_end && w_arb_hit) begin
               w_grant_now = 1'b1;
               w_tmo_clr   = 1'b1;
               w_state_nxt = S_GO;
            end
         end
         S_GO: begin
            if (!m_end) begin
               w_tmo_clr   = 1'b1;
               w_state_nxt = S_RUN;
            end else if (w_tmo_hit) begin
               w_fin       = 1'b1;
               w_fin_nack  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (m_end) begin
               w_state_nxt = S_CHECK;
            end else if (w_tmo_hit) begin
               w_fin       = 1'b1;
               w_fin_nack  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_CHECK: begin
            if (!m_ack) begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_retry < C_MAX_RETRY) begin
               w_retry_inc = 1'b1;
               w_tmo_clr   = 1'b1;
               w_state_nxt = S_GO;
            end else begin
               w_fin       = 1'b1;
               w_fin_nack  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_m_data     <= 24'd0;
         r_grant      <= 2'd0;
         r_last_grant <= C_LAST_RST;
         r_retry      <= '0;
         r_tmo        <= '0;
         r_req_ready  <= '0;
         r_done       <= '0;
         r_nack       <= '0;
      end else begin
         r_req_ready <= '0;
         r_done      <= '0;
         r_nack      <= '0;
         if (w_grant_now) begin
            r_m_data     <= w_word[w_arb_idx];
            r_grant      <= w_arb_idx;
            r_last_grant <= w_arb_idx;
            r_retry      <= '0;
            r_req_ready  <= w_arb_oh;
         end else if (w_retry_inc) begin
            r_retry <= r_retry + C_RW'(1);
         end
         if (w_tmo_clr) begin
            r_tmo <= '0;
         end else if ((r_state == S_GO || r_state == S_RUN) && r_tmo != C_TMO_MAX) begin
            r_tmo <= r_tmo + C_TW'(1);
         end
         if (w_fin) begin
            r_done <= w_grant_oh;
            r_nack <= w_fin_nack ? w_grant_oh : '0;
         end
      end
   end

   // START is decoded from state so an asynchronous reset removes it at once.
   assign m_start   = (r_state == S_GO);
   assign busy      = (r_state != S_IDLE);
   assign m_data    = r_m_data;
   assign grant_id  = r_grant;
   assign req_ready = r_req_ready;
   assign done      = r_done;
   assign nack      = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_i2c_arbiter: directed self-checking bench for i2c_arbiter. Rev 1.0
//------------------------------------------------------------------------------
module tb_i2c_arbiter;

   localparam int NREQ      = 3;
   localparam int MAX_RETRY = 3;
   localparam int TIMEOUT   = 16;
   localparam logic [23:0] D0 = 24'h729803;
   localparam logic [23:0] D1 = 24'h501AC3;
   localparam logic [23:0] D2 = 24'h3C027F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    req_valid = 3'b000;
   logic [71:0]   req_data = {D2, D1, D0};
   logic [2:0]    req_ready;
   logic [2:0]    done;
   logic [2:0]    nack;
   logic          m_start;
   logic [23:0]   m_data;
   logic          m_end = 1'b1;
   logic          m_ack = 1'b0;
   logic          busy;
   logic [1:0]    grant_id;

   int vectors = 0;
   int miscompares = 0;

   int   n_starts = 0;
   int   n_done = 0;
   int   n_ready = 0;
   int   n_overlap = 0;
   logic prev_ms = 1'b0;

   always #5 clk = ~clk;

   i2c_arbiter #(
      .NREQ      (NREQ),
      .MAX_RETRY (MAX_RETRY),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .done      (done),
      .nack      (nack),
      .m_start   (m_start),
      .m_data    (m_data),
      .m_end     (m_end),
      .m_ack     (m_ack),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   // Passive observers: START edges, pulse counts, ready/done collisions.
   always @(negedge clk) begin
      if (m_start && !prev_ms) n_starts++;
      prev_ms = m_start;
      if (done != 3'b000) n_done++;
      if (req_ready != 3'b000) n_ready++;
      if ((done & req_ready) != 3'b000 || $countones(done) > 1) n_overlap++;
   end

   task automatic wait_ready();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_ready != 3'b000) break;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done != 3'b000) break;
      end
   endtask

   // Engine model: accepts START, stays busy a few cycles, returns ack.
   task automatic engine_xfer(input logic ack);
      int i;
      i = 0;
      while (!m_start && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (!m_start) begin
         vectors++;
         miscompares++;
         $display("FAIL engine_start_wait: m_start=%b required 1 within 40 cycles", m_start);
         return;
      end
      repeat (2) @(negedge clk);
      m_end = 1'b0;
      repeat (3) @(negedge clk);
      m_ack = ack;
      m_end = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_end = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({m_start, busy, req_ready, done, nack, grant_id} !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: start/busy/ready/done/nack/grant=%b required 0",
                  {m_start, busy, req_ready, done, nack, grant_id});
      end
      vectors++;
      if (m_data !== 24'd0) begin
         miscompares++;
         $display("FAIL reset_mdata: m_data=%h required 000000", m_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_single();
      req_valid = 3'b001;
      wait_ready();
      vectors++;
      if (req_ready !== 3'b001 || m_data !== D0 || grant_id !== 2'd0 || m_start !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant: ready=%b m_data=%h grant=%0d start=%b required 001 %h 0 1",
                  req_ready, m_data, grant_id, m_start, D0);
      end
      req_valid = 3'b000;
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b000 || m_start !== 1'b1) begin
         miscompares++;
         $display("FAIL single_ready_pulse: ready=%b start=%b required 000 1", req_ready, m_start);
      end
      engine_xfer(1'b0);
      wait_done();
      vectors++;
      if (done !== 3'b001 || nack !== 3'b000) begin
         miscompares++;
         $display("FAIL single_done: done=%b nack=%b required 001 000", done, nack);
      end
      @(negedge clk);
      vectors++;
      if (done !== 3'b000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done_pulse: done=%b busy=%b required 000 0", done, busy);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_id;
      logic [23:0] exp_word;
      logic [2:0]  exp_oh;
      int          ov_base;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ov_base = n_overlap;
      req_valid = 3'b111;
      for (int n = 0; n < 6; n++) begin
         exp_id   = 2'(n % 3);
         exp_word = (n % 3 == 0) ? D0 : ((n % 3 == 1) ? D1 : D2);
         exp_oh   = 3'b001 << exp_id;
         wait_ready();
         vectors++;
         if (grant_id !== exp_id || req_ready !== exp_oh || m_data !== exp_word) begin
            miscompares++;
            $display("FAIL rr_grant_%0d: grant=%0d ready=%b m_data=%h required %0d %b %h",
                     n, grant_id, req_ready, m_data, exp_id, exp_oh, exp_word);
         end
         engine_xfer(1'b0);
         wait_done();
         vectors++;
         if (done !== exp_oh || nack !== 3'b000) begin
            miscompares++;
            $display("FAIL rr_done_%0d: done=%b nack=%b required %b 000", n, done, nack, exp_oh);
         end
      end
      req_valid = 3'b000;
      repeat (2) @(negedge clk);
      vectors++;
      if (n_overlap - ov_base !== 0) begin
         miscompares++;
         $display("FAIL rr_overlap: collisions=%0d required 0", n_overlap - ov_base);
      end
   endtask

   task automatic test_nack_retry();
      int base;
      base = n_starts;
      req_valid = 3'b001;
      wait_ready();
      req_valid = 3'b000;
      for (int a = 0; a < 4; a++) engine_xfer(1'b1);
      wait_done();
      vectors++;
      if (done !== 3'b001 || nack !== 3'b001 || m_data !== D0) begin
         miscompares++;
         $display("FAIL retry_all_nack: done=%b nack=%b m_data=%h required 001 001 %h",
                  done, nack, m_data, D0);
      end
      vectors++;
      if (n_starts - base !== 4) begin
         miscompares++;
         $display("FAIL retry_start_count: starts=%0d required 4", n_starts - base);
      end
      @(negedge clk);
      base = n_starts;
      req_valid = 3'b001;
      wait_ready();
      req_valid = 3'b000;
      engine_xfer(1'b1);
      engine_xfer(1'b1);
      engine_xfer(1'b0);
      wait_done();
      vectors++;
      if (done !== 3'b001 || nack !== 3'b000 || n_starts - base !== 3) begin
         miscompares++;
         $display("FAIL retry_third_ack: done=%b nack=%b starts=%0d required 001 000 3",
                  done, nack, n_starts - base);
      end
   endtask

   task automatic test_timeout();
      m_end = 1'b1;
      req_valid = 3'b010;
      wait_ready();
      req_valid = 3'b000;
      repeat (15) @(negedge clk);
      vectors++;
      if (m_start !== 1'b1 || done !== 3'b000) begin
         miscompares++;
         $display("FAIL timeout_last_go: start=%b done=%b required 1 000", m_start, done);
      end
      @(negedge clk);
      vectors++;
      if (m_start !== 1'b0 || done !== 3'b010 || nack !== 3'b010 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_fire: start=%b done=%b nack=%b busy=%b required 0 010 010 0",
                  m_start, done, nack, busy);
      end
      @(negedge clk);
      vectors++;
      if (done !== 3'b000 || m_start !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_after: done=%b start=%b required 000 0", done, m_start);
      end
   endtask

   task automatic test_reset_mid();
      int rb;
      int db;
      req_valid = 3'b100;
      wait_ready();
      req_valid = 3'b000;
      repeat (2) @(negedge clk);
      m_end = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (m_start !== 1'b0 || busy !== 1'b0 || done !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_async: start=%b busy=%b done=%b required 0 0 000", m_start, busy, done);
      end
      req_valid = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      rb = n_ready;
      db = n_done;
      repeat (5) @(negedge clk);
      vectors++;
      if (n_ready - rb !== 0 || n_done - db !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_hold_off: readies=%0d dones=%0d busy=%b required 0 0 0",
                  n_ready - rb, n_done - db, busy);
      end
      m_end = 1'b1;
      wait_ready();
      vectors++;
      if (req_ready !== 3'b001 || grant_id !== 2'd0 || m_data !== D0) begin
         miscompares++;
         $display("FAIL rst_first_grant: ready=%b grant=%0d m_data=%h required 001 0 %h",
                  req_ready, grant_id, m_data, D0);
      end
      req_valid = 3'b000;
      engine_xfer(1'b0);
      wait_done();
      vectors++;
      if (done !== 3'b001 || nack !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_recover_done: done=%b nack=%b required 001 000", done, nack);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_nack_retry();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning number of requesters (legal range 2..4).
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, meaning re-attempts after a NACK; total attempts are MAX_RETRY+1.
REQ-003 The block SHALL have parameter TIMEOUT, default 1_000_000, meaning clock cycles allowed in each engine-wait state.
REQ-004 The block SHALL have port iCLK, input, 1 bit: clock.
REQ-005 The block SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester transfer request.
REQ-007 The block SHALL have port req_data, input, 24*NREQ bits: per-requester {slave_addr, sub_addr, data}; requester i occupies bits [24i+23:24i].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-cycle accept pulse.
REQ-009 The block SHALL have port done, output, NREQ bits: one-cycle completion pulse.
REQ-010 The block SHALL have port nack, output, NREQ bits: failure flag, valid only together with done.
REQ-011 The block SHALL have port m_start, output, 1 bit: level START to the I2C engine.
REQ-012 The block SHALL have port m_data, output, 24 bits: transfer word to the engine.
REQ-013 The block SHALL have port m_end, input, 1 bit: engine idle (1) / busy (0).
REQ-014 The block SHALL have port m_ack, input, 1 bit: engine result, 0 = acked, 1 = NACK; valid when m_end is 1 after a transfer.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port grant_id, output, 2 bits: index of the owning requester; holds its value while not busy.

Function
REQ-017 The FSM SHALL have states IDLE, GO, RUN and CHECK.
REQ-018 IDLE SHALL arbitrate only when m_end=1 and at least one req_valid bit is 1.
REQ-019 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo NREQ.
REQ-020 On grant of requester g, the block SHALL, on the next edge:
- latch req_data[g] into m_data;
- set grant_id=g and last_grant=g;
- clear the retry counter;
- drive req_ready[g]=1 for exactly one cycle;
- go to GO with m_start=1.
REQ-021 Requesters SHALL hold req_valid and req_data stable until req_ready is seen; req_valid sampled outside IDLE SHALL be ignored.
REQ-022 GO SHALL hold m_start=1 until m_end=0 is sampled, then go to RUN.
REQ-023 RUN SHALL hold m_start=0 until m_end=1 is sampled, then go to CHECK.
REQ-024 CHECK (one cycle) SHALL behave on m_ack as follows:
- m_ack=0: pulse done[g] with nack[g]=0 and return to IDLE.
- m_ack=1 and retry<MAX_RETRY: increment retry and go to GO.
- m_ack=1 and retry=MAX_RETRY: pulse done[g] with nack[g]=1 and return to IDLE.
REQ-025 A timeout counter SHALL clear on entry to GO and RUN; reaching TIMEOUT in either state SHALL do all of the following:
- force m_start=0;
- pulse done[g] and nack[g];
- return to IDLE without retry.
REQ-026 m_data SHALL remain constant from grant until the next grant, including across retries.
REQ-027 done and req_ready for the same requester SHALL never be high in the same cycle; at most one bit of done is high per cycle.
REQ-028 After returning to IDLE, the next arbitration SHALL occur no earlier than the following cycle.
REQ-029 When a single requester is continuously valid, it SHALL be re-granted on each IDLE visit.
REQ-030 Width rules:
- the retry counter SHALL be wide enough for MAX_RETRY without wrap;
- the timeout counter SHALL saturate at TIMEOUT;
- the last_grant increment SHALL wrap at NREQ, not at 4.

Reset
REQ-031 While iRST_N=0, the block SHALL be in IDLE, with these values:
- all outputs 0 (m_start, m_data, req_ready, done, nack, busy, grant_id);
- retry and timeout counters 0;
- last_grant=NREQ-1, so requester 0 wins first.
REQ-032 Reset asserted mid-transfer SHALL drop m_start immediately (asynchronously) with no done pulse.
REQ-033 After reset release, the block SHALL not arbitrate until m_end=1.

Verification
REQ-034 Single request: req_valid=001, req_data[23:0]=72_98_03, engine acks -> req_ready=001 for 1 cycle, m_data=729803, m_start high until m_end falls, then done=001 and nack=000.
REQ-035 Round-robin: req_valid=111 held, each request re-asserted after its done -> grant order 0,1,2,0,1,2.
REQ-036 NACK retry: engine returns m_ack=1 on all attempts, MAX_RETRY=3 -> exactly 4 m_start assertions, then one done with nack set; with m_ack=0 on the 3rd attempt -> 3 assertions and nack=0.
REQ-037 Timeout: m_end held at 1 after grant, TIMEOUT=16 -> m_start drops after 16 cycles in GO, then done and nack pulse, then IDLE.
REQ-038 Reset during RUN: m_start and busy go 0 without waiting for a clock edge, no done pulse; with m_end held 0 after release -> no grant until m_end=1; first grant goes to requester 0.
